// File: rtl/instr_fetch_if.sv
// ============================================================================
// Module      : instr_fetch_if
// Description : Instruction-memory request/acknowledge handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module      : instr_fetch
// Description : Fetch stage: PC register, imem handshake FSM, instruction latch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        PCSel,
    input  wire logic [31:0] alu_target,
    input  wire logic        stall,
    instr_fetch_if.master    imem,
    output      logic [31:0] I,
    output      logic [31:0] pc_out,
    output      logic        instr_valid,
    output      logic        fetch_err,
    output      logic [31:0] instret
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_valid;
    logic        r_req;
    logic        r_err;
    logic [31:0] r_instret;
    logic [31:0] w_next_pc;
    logic        w_misaligned;

    // Branch targets are forced word-aligned; a misaligned one is flagged, not trapped.
    assign w_next_pc    = PCSel ? {alu_target[31:2], 2'b00} : r_pc + 32'd4;
    assign w_misaligned = PCSel && (alu_target[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_instr   <= NOP_INSTR;
            r_valid   <= 1'b0;
            r_req     <= 1'b0;
            r_err     <= 1'b0;
            r_instret <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req   <= 1'b1;
                    r_state <= S_REQ;
                end
                S_REQ: begin
                    if (imem.imem_ack) begin
                        r_instr <= imem.imem_rdata;
                        r_valid <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Advance takes priority over any stray ack arriving here.
                    if (!stall) begin
                        r_pc      <= w_next_pc;
                        r_instret <= r_instret + 32'd1;
                        r_valid   <= 1'b0;
                        r_instr   <= NOP_INSTR;
                        r_req     <= 1'b1;
                        r_state   <= S_REQ;
                        if (w_misaligned) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = r_req;
    assign imem.imem_addr = r_pc;
    assign I              = r_instr;
    assign pc_out         = r_pc;
    assign instr_valid    = r_valid;
    assign fetch_err      = r_err;
    assign instret        = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        PCSel;
    logic [31:0] alu_target;
    logic        stall;
    logic [31:0] I;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        fetch_err;
    logic [31:0] instret;

    int n_checks;
    int n_errors;

    instr_fetch_if u_if ();

    instr_fetch #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (C_NOP)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .PCSel       (PCSel),
        .alu_target  (alu_target),
        .stall       (stall),
        .imem        (u_if),
        .I           (I),
        .pc_out      (pc_out),
        .instr_valid (instr_valid),
        .fetch_err   (fetch_err),
        .instret     (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks the full observable state in one call.
    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_i,
                             input logic e_v, input logic e_req, input logic e_err,
                             input logic [31:0] e_ret);
        check({tag, ".pc"},    pc_out, e_pc);
        check({tag, ".addr"},  u_if.imem_addr, e_pc);
        check({tag, ".I"},     I, e_i);
        check({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, e_v});
        check({tag, ".req"},   {31'd0, u_if.imem_req}, {31'd0, e_req});
        check({tag, ".err"},   {31'd0, fetch_err}, {31'd0, e_err});
        check({tag, ".ret"},   instret, e_ret);
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        rst             = 1'b1;
        PCSel           = 1'b0;
        alu_target      = 32'd0;
        stall           = 1'b0;
        u_if.imem_ack   = 1'b0;
        u_if.imem_rdata = 32'd0;

        tick();
        tick();
        check_all("reset", 32'h0, C_NOP, 1'b0, 1'b0, 1'b0, 32'd0);

        // Sequential fetch from reset
        rst = 1'b0;
        tick();
        check_all("idle2req", 32'h0, C_NOP, 1'b0, 1'b1, 1'b0, 32'd0);
        u_if.imem_ack = 1'b1; u_if.imem_rdata = 32'h0050_0093;
        tick();
        u_if.imem_ack = 1'b0;
        check_all("fetch0", 32'h0, 32'h0050_0093, 1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        check_all("adv0", 32'h4, C_NOP, 1'b0, 1'b1, 1'b0, 32'd1);
        u_if.imem_ack = 1'b1; u_if.imem_rdata = 32'h00A0_0113;
        tick();
        u_if.imem_ack = 1'b0;
        check_all("fetch1", 32'h4, 32'h00A0_0113, 1'b1, 1'b0, 1'b0, 32'd1);
        tick();
        check_all("adv1", 32'h8, C_NOP, 1'b0, 1'b1, 1'b0, 32'd2);

        // Taken branch from pc 0x8
        u_if.imem_ack = 1'b1; u_if.imem_rdata = 32'h0000_006F;
        tick();
        u_if.imem_ack = 1'b0;
        PCSel = 1'b1; alu_target = 32'h0000_0040;
        tick();
        PCSel = 1'b0; alu_target = 32'hDEAD_BEEF;
        check_all("branch", 32'h40, C_NOP, 1'b0, 1'b1, 1'b0, 32'd3);

        // Stall in HOLD for 5 cycles with a stray ack on one of them
        u_if.imem_ack = 1'b1; u_if.imem_rdata = 32'h1234_5678;
        tick();
        u_if.imem_ack = 1'b0;
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                u_if.imem_ack = 1'b1; u_if.imem_rdata = 32'hBAD0_BAD0;
                PCSel = 1'b1;
            end else begin
                u_if.imem_ack = 1'b0;
                PCSel = 1'b0;
            end
            tick();
            check_all("stall", 32'h40, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'd3);
        end
        u_if.imem_ack = 1'b0; PCSel = 1'b0;
        stall = 1'b0;
        tick();
        stall = 1'b1;
        check_all("unstall", 32'h44, C_NOP, 1'b0, 1'b1, 1'b0, 32'd4);

        // Slow memory: no ack for 7 cycles, stall ignored outside HOLD
        for (int k = 0; k < 7; k++) begin
            tick();
            check_all("slow", 32'h44, C_NOP, 1'b0, 1'b1, 1'b0, 32'd4);
        end
        stall = 1'b0;
        u_if.imem_ack = 1'b1; u_if.imem_rdata = 32'hCAFE_0001;
        tick();
        check_all("slowack", 32'h44, 32'hCAFE_0001, 1'b1, 1'b0, 1'b0, 32'd4);

        // Advance while ack is also high: ack must be ignored in HOLD
        u_if.imem_rdata = 32'hCAFE_0002;
        tick();
        u_if.imem_ack = 1'b0;
        check_all("advack", 32'h48, C_NOP, 1'b0, 1'b1, 1'b0, 32'd5);

        // Misaligned target 0x102
        u_if.imem_ack = 1'b1; u_if.imem_rdata = 32'h0000_0001;
        tick();
        u_if.imem_ack = 1'b0;
        PCSel = 1'b1; alu_target = 32'h0000_0102;
        tick();
        check_all("misalign", 32'h100, C_NOP, 1'b0, 1'b1, 1'b1, 32'd6);

        // Jump to 0xFFFFFFFC then wrap sequentially to 0
        u_if.imem_ack = 1'b1; u_if.imem_rdata = 32'h0000_0002;
        tick();
        u_if.imem_ack = 1'b0;
        alu_target = 32'hFFFF_FFFC;
        tick();
        PCSel = 1'b0;
        check_all("jmptop", 32'hFFFF_FFFC, C_NOP, 1'b0, 1'b1, 1'b1, 32'd7);
        u_if.imem_ack = 1'b1; u_if.imem_rdata = 32'h0000_0003;
        tick();
        u_if.imem_ack = 1'b0;
        tick();
        check_all("wrap", 32'h0, C_NOP, 1'b0, 1'b1, 1'b1, 32'd8);

        // One more advance to pc 0x4, then reset between edges during REQ
        u_if.imem_ack = 1'b1; u_if.imem_rdata = 32'h0000_0004;
        tick();
        u_if.imem_ack = 1'b0;
        tick();
        check_all("prerst", 32'h4, C_NOP, 1'b0, 1'b1, 1'b1, 32'd9);
        #2;
        rst = 1'b1;
        #1;
        check_all("asyncrst", 32'h0, C_NOP, 1'b0, 1'b0, 1'b0, 32'd0);
        u_if.imem_ack = 1'b1; u_if.imem_rdata = 32'h5555_5555;
        tick();
        check_all("rstack", 32'h0, C_NOP, 1'b0, 1'b0, 1'b0, 32'd0);
        rst = 1'b0;
        tick();
        check_all("idleack", 32'h0, C_NOP, 1'b0, 1'b1, 1'b0, 32'd0);
        tick();
        u_if.imem_ack = 1'b0;
        check_all("refetch", 32'h0, 32'h5555_5555, 1'b1, 1'b0, 1'b0, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
